// File: rtl/video_rotozoom_if.sv
// rtl/video_rotozoom_if.sv - register, CPU write, SRAM and video signals of the rotozoom block
interface video_rotozoom_if #(
    parameter int CW = 8
);
    logic          reg_we;
    logic [2:0]    reg_addr;
    logic [15:0]   reg_wdata;

    logic          cpu_wreq;
    logic [18:0]   cpu_waddr;
    logic [7:0]    cpu_wdata;
    logic          cpu_wready;

    logic [15:0]   sram_dq;
    logic [17:0]   sram_addr;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic          sram_lb_n;
    logic          sram_ub_n;

    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
    logic          hs;
    logic          vs;
    logic          de;
    logic          frame_irq;

    modport master (
        output reg_we, reg_addr, reg_wdata,
        output cpu_wreq, cpu_waddr, cpu_wdata,
        input  cpu_wready,
        output sram_dq,
        input  sram_addr, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n,
        input  r, g, b, hs, vs, de, frame_irq
    );

    modport slave (
        input  reg_we, reg_addr, reg_wdata,
        input  cpu_wreq, cpu_waddr, cpu_wdata,
        output cpu_wready,
        input  sram_dq,
        output sram_addr, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n,
        output r, g, b, hs, vs, de, frame_irq
    );
endinterface

// File: rtl/video_rotozoom.sv
// rtl/video_rotozoom.sv - programmable raster timing with affine SRAM bitmap fetch and CPU write FIFO
module video_rotozoom #(
    parameter int H_FRONT     = 48,
    parameter int H_SYNC      = 112,
    parameter int H_BACK      = 248,
    parameter int H_VIS       = 1280,
    parameter int V_FRONT     = 1,
    parameter int V_SYNC      = 3,
    parameter int V_BACK      = 38,
    parameter int V_VIS       = 1024,
    parameter int FRAC        = 12,
    parameter int WFIFO_DEPTH = 4,
    parameter int CW          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    video_rotozoom_if.slave  bus
);
    localparam int HTOT = H_FRONT + H_SYNC + H_BACK + H_VIS;
    localparam int VTOT = V_FRONT + V_SYNC + V_BACK + V_VIS;
    localparam int HVS  = H_FRONT + H_SYNC + H_BACK;
    localparam int VVS  = V_FRONT + V_SYNC + V_BACK;
    localparam int HW   = $clog2(HTOT);
    localparam int VW   = $clog2(VTOT);
    localparam int AW   = 9 + FRAC + 4;
    localparam int PW   = $clog2(WFIFO_DEPTH);

    logic [HW-1:0] hcnt, hcnt_nxt;
    logic [VW-1:0] vcnt, vcnt_nxt;
    logic          h_last, v_last, frame_last;
    logic          vis_line, win, fetch_start;

    assign h_last      = (hcnt == HW'(HTOT - 1));
    assign v_last      = (vcnt == VW'(VTOT - 1));
    assign frame_last  = h_last && v_last;
    assign vis_line    = (vcnt >= VW'(VVS));
    assign win         = vis_line && (hcnt >= HW'(HVS - 3)) && (hcnt <= HW'(HTOT - 4));
    assign fetch_start = vis_line && (hcnt == HW'(HVS - 3));

    always_comb begin
        hcnt_nxt = h_last ? '0 : hcnt + 1'b1;
        vcnt_nxt = vcnt;
        if (h_last) begin
            vcnt_nxt = v_last ? '0 : vcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            hcnt <= hcnt_nxt;
            vcnt <= vcnt_nxt;
        end
    end

    // Sync/de/irq are registered from the next counter value so they line up with hcnt itself.
    logic hs_q, vs_q, de_q, irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            de_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            hs_q  <= !((hcnt_nxt >= HW'(H_FRONT)) && (hcnt_nxt < HW'(H_FRONT + H_SYNC)));
            vs_q  <= !((vcnt_nxt >= VW'(V_FRONT)) && (vcnt_nxt < VW'(V_FRONT + V_SYNC)));
            de_q  <= (hcnt_nxt >= HW'(HVS)) && (vcnt_nxt >= VW'(VVS));
            irq_q <= (hcnt_nxt == '0) && (vcnt_nxt == '0);
        end
    end

    logic [15:0] start_x, start_y, step_x, step_y;
    logic [1:0]  ctrl;
    logic [14:0] border;
    logic [15:0] sh_step_x, sh_step_y;
    logic        sh_en, sh_clamp;
    logic [14:0] sh_border;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_x <= '0;
            start_y <= '0;
            step_x  <= 16'(1 << FRAC);
            step_y  <= '0;
            ctrl    <= '0;
            border  <= '0;
        end else if (bus.reg_we) begin
            case (bus.reg_addr)
                3'd0:    start_x <= bus.reg_wdata;
                3'd1:    start_y <= bus.reg_wdata;
                3'd2:    step_x  <= bus.reg_wdata;
                3'd3:    step_y  <= bus.reg_wdata;
                3'd4:    ctrl    <= bus.reg_wdata[1:0];
                3'd5:    border  <= bus.reg_wdata[14:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_step_x <= 16'(1 << FRAC);
            sh_step_y <= '0;
            sh_en     <= 1'b0;
            sh_clamp  <= 1'b0;
            sh_border <= '0;
        end else if (frame_last) begin
            sh_step_x <= step_x;
            sh_step_y <= step_y;
            sh_en     <= ctrl[0];
            sh_clamp  <= ctrl[1];
            sh_border <= border;
        end
    end

    logic signed [AW-1:0] line_x, line_y, pix_x, pix_y, cur_x, cur_y;
    logic signed [AW-1:0] dx, dy, load_x, load_y;
    logic                 oob;

    assign dx     = AW'($signed(sh_step_x));
    assign dy     = AW'($signed(sh_step_y));
    assign load_x = AW'($signed(start_x)) <<< FRAC;
    assign load_y = AW'($signed(start_y)) <<< FRAC;
    assign cur_x  = fetch_start ? line_x : pix_x;
    assign cur_y  = fetch_start ? line_y : pix_y;
    assign oob    = (|cur_x[AW-1:FRAC+9]) || (|cur_y[AW-1:FRAC+9]);

    // Line start walks perpendicular to the pixel step: (-STEP_Y, STEP_X).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_x <= '0;
            line_y <= '0;
            pix_x  <= '0;
            pix_y  <= '0;
        end else begin
            if (frame_last) begin
                line_x <= load_x;
                line_y <= load_y;
            end else if (fetch_start) begin
                line_x <= line_x - dy;
                line_y <= line_y + dx;
            end
            if (win) begin
                pix_x <= cur_x + dx;
                pix_y <= cur_y + dy;
            end
        end
    end

    logic [18:0] fifo_addr [WFIFO_DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;
    logic        fifo_full, fifo_empty, push, pop;
    logic [18:0] head_addr;

    assign fifo_empty     = (wr_ptr == rd_ptr);
    assign fifo_full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign push           = bus.cpu_wreq && !fifo_full;
    assign pop            = !win && !fifo_empty;
    assign head_addr      = fifo_addr[rd_ptr[PW-1:0]];
    assign bus.cpu_wready = !fifo_full;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr[PW-1:0]] <= bus.cpu_waddr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Stage 1: SRAM control register; the fetch window always wins over FIFO drain.
    logic [17:0] sram_addr_q;
    logic        oe_n_q, we_n_q, lb_n_q, ub_n_q;
    logic        p1, use1, p2, use2;
    logic [14:0] dq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_addr_q <= '0;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            p1          <= 1'b0;
            use1        <= 1'b0;
        end else begin
            p1   <= win;
            use1 <= win && sh_en && !(sh_clamp && oob);
            if (win) begin
                sram_addr_q <= {cur_y[FRAC+8:FRAC], cur_x[FRAC+8:FRAC]};
                oe_n_q      <= !sh_en;
                we_n_q      <= 1'b1;
                lb_n_q      <= !sh_en;
                ub_n_q      <= !sh_en;
            end else if (pop) begin
                sram_addr_q <= head_addr[18:1];
                oe_n_q      <= 1'b1;
                we_n_q      <= 1'b0;
                lb_n_q      <= head_addr[0];
                ub_n_q      <= !head_addr[0];
            end else begin
                oe_n_q      <= 1'b1;
                we_n_q      <= 1'b1;
                lb_n_q      <= 1'b1;
                ub_n_q      <= 1'b1;
            end
        end
    end

    function automatic logic [CW-1:0] chan(input logic [4:0] c);
        return CW'(c) << (CW - 5);
    endfunction

    logic [CW-1:0] r_q, g_q, b_q;
    logic [14:0]   pix;

    assign pix = use2 ? dq_q : sh_border;

    // Stage 2 samples dq; stage 3 forms the colour, zero outside the pixel slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p2   <= 1'b0;
            use2 <= 1'b0;
            dq_q <= '0;
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
        end else begin
            p2   <= p1;
            use2 <= use1;
            dq_q <= bus.sram_dq[14:0];
            r_q  <= p2 ? chan(pix[14:10]) : '0;
            g_q  <= p2 ? chan(pix[9:5])   : '0;
            b_q  <= p2 ? chan(pix[4:0])   : '0;
        end
    end

    assign bus.sram_addr = sram_addr_q;
    assign bus.sram_oe_n = oe_n_q;
    assign bus.sram_we_n = we_n_q;
    assign bus.sram_lb_n = lb_n_q;
    assign bus.sram_ub_n = ub_n_q;
    assign bus.r         = r_q;
    assign bus.g         = g_q;
    assign bus.b         = b_q;
    assign bus.hs        = hs_q;
    assign bus.vs        = vs_q;
    assign bus.de        = de_q;
    assign bus.frame_irq = irq_q;
endmodule

// File: tb/tb_video_rotozoom.sv
// tb/tb_video_rotozoom.sv - directed self-checking bench for video_rotozoom on a small geometry
module tb_video_rotozoom;
    localparam int HTOT  = 17;
    localparam int FRAME = 136;
    localparam int HVS   = 9;
    localparam int VVS   = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    video_rotozoom_if #(.CW(8)) bus();

    video_rotozoom #(
        .H_FRONT(2), .H_SYNC(3), .H_BACK(4), .H_VIS(8),
        .V_FRONT(1), .V_SYNC(1), .V_BACK(2), .V_VIS(4),
        .FRAC(12), .WFIFO_DEPTH(4), .CW(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0] mem [0:262143];
    assign bus.sram_dq = mem[bus.sram_addr];

    int checks = 0;
    int errors = 0;

    logic [23:0] cap_rgb [0:FRAME-1];
    logic        cap_de  [0:FRAME-1];
    logic        cap_hs  [0:FRAME-1];
    logic        cap_vs  [0:FRAME-1];
    logic        cap_irq [0:FRAME-1];
    logic        cap_oe  [0:FRAME-1];

    function automatic logic [23:0] col(input logic [15:0] w);
        return {w[14:10], 3'b000, w[9:5], 3'b000, w[4:0], 3'b000};
    endfunction

    // Expected colour of pixel k on visible line j; the bitmap holds x^y at {y,x}.
    function automatic logic [23:0] exp_pix(input int sx, input int sy, input int stx, input int sty,
                                            input logic en, input logic clamp, input logic [15:0] border,
                                            input int k, input int j);
        longint ax, ay;
        int x, y;
        if (!en) return col(border);
        ax = ((longint'(sx) <<< 12) + longint'(k) * stx - longint'(j) * sty) & 64'h1FF_FFFF;
        ay = ((longint'(sy) <<< 12) + longint'(k) * sty + longint'(j) * stx) & 64'h1FF_FFFF;
        if (clamp && (((ax >> 21) != 0) || ((ay >> 21) != 0))) return col(border);
        x = int'((ax >> 12) & 511);
        y = int'((ay >> 12) & 511);
        return col(16'(x ^ y));
    endfunction

    task automatic wait_irq();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.frame_irq !== 1'b1 && n < 400);
        if (bus.frame_irq !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_irq: frame_irq=%b after %0d cycles, required 1", bus.frame_irq, n);
        end
    endtask

    task automatic capture_frame(input bit sync);
        if (sync) wait_irq();
        for (int i = 0; i < FRAME; i++) begin
            cap_rgb[i] = {bus.r, bus.g, bus.b};
            cap_de[i]  = bus.de;
            cap_hs[i]  = bus.hs;
            cap_vs[i]  = bus.vs;
            cap_irq[i] = bus.frame_irq;
            cap_oe[i]  = bus.sram_oe_n;
            @(posedge clk); #1;
        end
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [15:0] d);
        bus.reg_we    = 1'b1;
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        @(posedge clk); #1;
        bus.reg_we    = 1'b0;
    endtask

    task automatic test_reset();
        int n = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.hs, bus.vs, bus.de, bus.frame_irq} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_sync: hs/vs/de/irq=%b, required 1100", {bus.hs, bus.vs, bus.de, bus.frame_irq});
        end
        checks++;
        if ({bus.r, bus.g, bus.b} !== 24'h0) begin
            errors++;
            $display("FAIL reset_rgb: rgb=%h, required 000000", {bus.r, bus.g, bus.b});
        end
        checks++;
        if ({bus.sram_oe_n, bus.sram_we_n, bus.sram_lb_n, bus.sram_ub_n, bus.cpu_wready} !== 5'b11111
            || bus.sram_addr !== 18'h0) begin
            errors++;
            $display("FAIL reset_sram: oe/we/lb/ub/wready=%b addr=%h, required 11111 addr=00000",
                     {bus.sram_oe_n, bus.sram_we_n, bus.sram_lb_n, bus.sram_ub_n, bus.cpu_wready}, bus.sram_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.hs !== 1'b0 && n < 100);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL reset_hs_fall: hs fell after %0d clocks, required 2", n);
        end
    endtask

    task automatic test_timing();
        int de_n = 0, hs_low = 0, vs_low = 0, irq_n = 0, oe_n = 0, first_de = -1;
        capture_frame(1);
        for (int i = 0; i < FRAME; i++) begin
            if (cap_de[i] === 1'b1) begin
                de_n++;
                if (first_de < 0) first_de = i;
            end
            if (cap_hs[i] === 1'b0) hs_low++;
            if (cap_vs[i] === 1'b0) vs_low++;
            if (cap_irq[i] === 1'b1) irq_n++;
            if (cap_oe[i] === 1'b0) oe_n++;
        end
        checks++;
        if (de_n != 32) begin errors++; $display("FAIL timing_de_count: %0d, required 32", de_n); end
        checks++;
        if (first_de != VVS * HTOT + HVS) begin errors++; $display("FAIL timing_first_de: %0d, required 77", first_de); end
        checks++;
        if (hs_low != 24) begin errors++; $display("FAIL timing_hs_low: %0d, required 24", hs_low); end
        checks++;
        if ({cap_hs[1], cap_hs[2], cap_hs[3], cap_hs[4], cap_hs[5]} !== 5'b10001) begin
            errors++;
            $display("FAIL timing_hs_pos: hs[1..5]=%b, required 10001",
                     {cap_hs[1], cap_hs[2], cap_hs[3], cap_hs[4], cap_hs[5]});
        end
        checks++;
        if (vs_low != 17) begin errors++; $display("FAIL timing_vs_low: %0d, required 17", vs_low); end
        checks++;
        if (irq_n != 1 || cap_irq[0] !== 1'b1) begin
            errors++;
            $display("FAIL timing_irq_once: count=%0d irq0=%b, required 1 and 1", irq_n, cap_irq[0]);
        end
        checks++;
        if (bus.frame_irq !== 1'b1) begin errors++; $display("FAIL timing_irq_period: irq=%b at +136, required 1", bus.frame_irq); end
        checks++;
        if (oe_n != 0) begin errors++; $display("FAIL timing_no_reads_disabled: oe low %0d, required 0", oe_n); end
    endtask

    task automatic test_identity();
        int oe_n = 0, noisy = 0;
        reg_write(3'd4, 16'h0001);
        capture_frame(1);
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 8; k++) begin
                int idx = (VVS + j) * HTOT + HVS + k;
                logic [23:0] e = exp_pix(0, 0, 4096, 0, 1'b1, 1'b0, 16'h0, k, j);
                checks++;
                if (cap_rgb[idx] !== e || cap_de[idx] !== 1'b1) begin
                    errors++;
                    $display("FAIL identity_pix j=%0d k=%0d: rgb=%h de=%b, required rgb=%h de=1", j, k, cap_rgb[idx], cap_de[idx], e);
                end
            end
        end
        for (int i = 0; i < FRAME; i++) begin
            if (cap_oe[i] === 1'b0) oe_n++;
            if (cap_de[i] !== 1'b1 && cap_rgb[i] !== 24'h0) noisy++;
        end
        checks++;
        if (oe_n != 32) begin errors++; $display("FAIL identity_reads: oe low %0d, required 32", oe_n); end
        checks++;
        if (noisy != 0) begin errors++; $display("FAIL identity_blank_rgb: %0d nonzero outside de, required 0", noisy); end
    endtask

    task automatic test_clamp();
        int base = VVS * HTOT + HVS;
        reg_write(3'd0, 16'hFFFE);
        reg_write(3'd5, 16'h7C00);
        reg_write(3'd4, 16'h0003);
        capture_frame(1);
        checks++;
        if (cap_rgb[base] !== 24'hF80000 || cap_rgb[base + 1] !== 24'hF80000) begin
            errors++;
            $display("FAIL clamp_border: %h %h, required f80000 f80000", cap_rgb[base], cap_rgb[base + 1]);
        end
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 8; k++) begin
                int idx = (VVS + j) * HTOT + HVS + k;
                logic [23:0] e = exp_pix(-2, 0, 4096, 0, 1'b1, 1'b1, 16'h7C00, k, j);
                checks++;
                if (cap_rgb[idx] !== e) begin
                    errors++;
                    $display("FAIL clamp_pix j=%0d k=%0d: rgb=%h, required %h", j, k, cap_rgb[idx], e);
                end
            end
        end
        reg_write(3'd4, 16'h0001);
        capture_frame(1);
        checks++;
        if (cap_rgb[base] !== 24'h0078F0) begin
            errors++;
            $display("FAIL wrap_x510: rgb=%h, required 0078f0", cap_rgb[base]);
        end
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 8; k++) begin
                int idx = (VVS + j) * HTOT + HVS + k;
                logic [23:0] e = exp_pix(-2, 0, 4096, 0, 1'b1, 1'b0, 16'h7C00, k, j);
                checks++;
                if (cap_rgb[idx] !== e) begin
                    errors++;
                    $display("FAIL wrap_pix j=%0d k=%0d: rgb=%h, required %h", j, k, cap_rgb[idx], e);
                end
            end
        end
    endtask

    task automatic test_disabled();
        int bad = 0, oe_n = 0;
        reg_write(3'd4, 16'h0000);
        capture_frame(1);
        for (int i = 0; i < FRAME; i++) begin
            if (cap_de[i] === 1'b1 && cap_rgb[i] !== 24'hF80000) bad++;
            if (cap_oe[i] === 1'b0) oe_n++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL disabled_border: %0d pixels not f80000, required 0", bad); end
        checks++;
        if (oe_n != 0) begin errors++; $display("FAIL disabled_reads: oe low %0d, required 0", oe_n); end
    endtask

    task automatic test_shadow();
        reg_write(3'd0, 16'h0000);
        reg_write(3'd4, 16'h0001);
        wait_irq();
        fork
            capture_frame(1);
            begin
                wait_irq();
                repeat (40) @(posedge clk);
                #1;
                reg_write(3'd2, 16'h2000);
            end
        join
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 8; k++) begin
                int idx = (VVS + j) * HTOT + HVS + k;
                logic [23:0] e = exp_pix(0, 0, 4096, 0, 1'b1, 1'b0, 16'h7C00, k, j);
                checks++;
                if (cap_rgb[idx] !== e) begin
                    errors++;
                    $display("FAIL shadow_old j=%0d k=%0d: rgb=%h, required %h", j, k, cap_rgb[idx], e);
                end
            end
        end
        capture_frame(0);
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 8; k++) begin
                int idx = (VVS + j) * HTOT + HVS + k;
                logic [23:0] e = exp_pix(0, 0, 8192, 0, 1'b1, 1'b0, 16'h7C00, k, j);
                checks++;
                if (cap_rgb[idx] !== e) begin
                    errors++;
                    $display("FAIL shadow_new j=%0d k=%0d: rgb=%h, required %h", j, k, cap_rgb[idx], e);
                end
            end
        end
    endtask

    task automatic test_fifo();
        logic [18:0] waddr [5] = '{19'h00011, 19'h00020, 19'h7FFFF, 19'h00102, 19'h00055};
        logic [19:0] exp_w [4] = '{{18'h00008, 2'b10}, {18'h00010, 2'b01}, {18'h3FFFF, 2'b10}, {18'h00081, 2'b01}};
        logic [19:0] got_w [8];
        int          got_c [8];
        int          w = 0;
        wait_irq();
        repeat (74) @(posedge clk);
        #1;
        for (int p = 0; p < 5; p++) begin
            checks++;
            if (bus.cpu_wready !== (p < 4)) begin
                errors++;
                $display("FAIL fifo_wready push=%0d: wready=%b, required %0d", p, bus.cpu_wready, p < 4);
            end
            bus.cpu_wreq  = 1'b1;
            bus.cpu_waddr = waddr[p];
            bus.cpu_wdata = 8'(8'hA0 + p);
            @(posedge clk); #1;
        end
        bus.cpu_wreq = 1'b0;
        for (int c = 79; c < 109; c++) begin
            if (bus.sram_we_n === 1'b0) begin
                if (w < 8) begin
                    got_w[w] = {bus.sram_addr, bus.sram_lb_n, bus.sram_ub_n};
                    got_c[w] = c;
                end
                w++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (w != 4) begin errors++; $display("FAIL fifo_write_count: %0d, required 4", w); end
        for (int i = 0; i < 4; i++) begin
            if (i < w) begin
                checks++;
                if (got_w[i] !== exp_w[i] || got_c[i] != 83 + i) begin
                    errors++;
                    $display("FAIL fifo_write%0d: addr/lb/ub=%h cycle=%0d, required %h cycle=%0d",
                             i, got_w[i], got_c[i], exp_w[i], 83 + i);
                end
            end
        end
        checks++;
        if (bus.cpu_wready !== 1'b1) begin errors++; $display("FAIL fifo_drained: wready=%b, required 1", bus.cpu_wready); end
    endtask

    task automatic test_midframe_reset();
        int wr = 0, rd = 0, first_irq = -1;
        wait_irq();
        repeat (74) @(posedge clk);
        #1;
        bus.cpu_wreq  = 1'b1;
        bus.cpu_waddr = 19'h00123;
        repeat (2) @(posedge clk);
        #1;
        bus.cpu_wreq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.de, bus.hs, bus.sram_oe_n, bus.sram_we_n, bus.cpu_wready} !== 5'b01111 || {bus.r, bus.g, bus.b} !== 24'h0) begin
            errors++;
            $display("FAIL midreset_outputs: de/hs/oe/we/wready=%b rgb=%h, required 01111 rgb=000000",
                     {bus.de, bus.hs, bus.sram_oe_n, bus.sram_we_n, bus.cpu_wready}, {bus.r, bus.g, bus.b});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 150; n++) begin
            @(posedge clk); #1;
            if (bus.sram_we_n === 1'b0) wr++;
            if (bus.sram_oe_n === 1'b0) rd++;
            if (bus.frame_irq === 1'b1 && first_irq < 0) first_irq = n;
        end
        checks++;
        if (wr != 0) begin errors++; $display("FAIL midreset_fifo_flush: %0d writes, required 0", wr); end
        checks++;
        if (rd != 0) begin errors++; $display("FAIL midreset_regs: %0d reads, required 0", rd); end
        checks++;
        if (first_irq != FRAME) begin errors++; $display("FAIL midreset_irq: first irq at %0d, required 136", first_irq); end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.reg_we    = 1'b0;
        bus.reg_addr  = 3'd0;
        bus.reg_wdata = 16'h0;
        bus.cpu_wreq  = 1'b0;
        bus.cpu_waddr = 19'h0;
        bus.cpu_wdata = 8'h0;
        for (int i = 0; i < 262144; i++) begin
            mem[i] = 16'(i[8:0] ^ i[17:9]);
        end
        test_reset();
        test_timing();
        test_identity();
        test_clamp();
        test_disabled();
        test_shadow();
        test_fifo();
        test_midframe_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
